alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised integer execute unit for RV32I OP-IMM (opcode 0010011) and OP (opcode 0110011) instructions. It accepts one instruction over a valid/ready handshake, reads rs1 and rs2 with a configurable register-file latency, and drives the shared ALU. It then returns the result on a writeback handshake. It sits between the decode stage and the register file. It supersedes the single-cycle, tri-stated immediate-only unit with actively driven outputs, register-register support, illegal-encoding detection and back-pressure.

## Interface
- XLEN, 32, datapath width (32 or 64)
- REG_SELECT_LEN, 5, register index width
- REG_READ_LATENCY, 1, cycles from register select to valid register data (1-4)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  unit in IDLE, can accept
- instruction  in  32  instruction word, sampled on accept
- register_1 / register_2  out  REG_SELECT_LEN  rs1/rs2 select
- register_data_1 / register_data_2  in  XLEN  rs1/rs2 data
- alu_a, alu_b  out  XLEN  ALU operands
- alu_op  out  3  ALU funct3
- alu_sig  out  1  ALU alternate (SUB/SRA)
- alu_out  in  XLEN  ALU result, combinational from alu_a/alu_b/alu_op/alu_sig
- wb_valid  out  1  result valid
- wb_ready  in  1  register file accepts
- output_register  out  REG_SELECT_LEN  rd
- output_register_data  out  XLEN  result
- illegal  out  1  one-cycle pulse: rejected encoding

## Operation
- States: IDLE, READ, EXEC, WB.
- Transitions:
  - IDLE→READ on instr_valid && instr_ready. The word is latched at this point.
  - READ holds REG_READ_LATENCY cycles (down-counter), then goes to EXEC.
  - EXEC→WB if rd≠0.
  - EXEC→IDLE if rd==0. The result is discarded and no wb_valid is raised.
  - WB→IDLE on wb_valid && wb_ready.
- Decode in IDLE on accept, from the incoming word. An illegal word:
  - pulses `illegal` in the following cycle;
  - returns the unit to IDLE, i.e. it does not enter READ.
- Illegal encodings:
  - opcode not in {0010011, 0110011};
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7=0100000 and funct3 not in {000, 101};
  - OP-IMM funct3=001 with imm[11:5]≠0000000;
  - OP-IMM funct3=101 with imm[11:5] not in {0000000, 0100000}.
- Operands:
  - alu_a = rs1 data.
  - OP: alu_b = rs2 data.
  - OP-IMM, non-shift: alu_b = imm[11:0] sign-extended to XLEN.
  - OP-IMM, shift: alu_b = zero-extended shamt. For XLEN=32, instruction[24:20] and bit 25 must be 0, otherwise illegal. For XLEN=64, instruction[25:20].
- alu_sig = instruction[30] only for OP funct3 000 and for funct3 101 (OP or OP-IMM). It is 0 for everything else; ADDI with imm bit 10 set gives alu_sig=0.
- register_1 = instruction[19:15] and register_2 = instruction[24:20], driven from READ through EXEC. They are 0 otherwise.
- alu_a/alu_b/alu_op/alu_sig are valid only in EXEC and are 0 otherwise. No output is ever high-impedance.
- alu_out is registered at the end of EXEC into output_register_data. That value and output_register stay stable throughout WB.

## Timing
- Reset: state=IDLE, instr_ready=1 after reset deassert. All other outputs 0; counter 0; `illegal` 0.
- rst has priority over every event and aborts any state, including WB with wb_valid high. No writeback completes after reset.
- Latency, accept cycle = 0: READ cycles 1..L, EXEC cycle L+1, wb_valid first high in cycle L+2. For L=1, wb_valid rises in cycle 3.
- Throughput: one instruction per L+3 cycles with wb_ready tied high.
- instr_ready is 0 in every non-IDLE state. An accept and a writeback never coincide.
- wb_valid, once raised, stays high until wb_ready. Data and rd must not change while waiting.

## Structure
- Package alu_pkg holds:
  - XLEN and REG_SELECT_LEN defaults;
  - opcode constants OPC_OP_IMM and OPC_OP;
  - funct3 enum (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND);
  - state enum (IDLE, READ, EXEC, WB).
- One sub-module, alu_exec_decode: a combinational decoder. Inputs: instruction. Outputs: is_imm, is_shift, alu_op, alu_sig, imm_ext, illegal. The top level keeps the FSM, counter and registers.

## Test plan
- ADDI x5,x1,-1 (0xFFF08293), x1=0x00000010, L=1: alu_b=0xFFFFFFFF, alu_sig=0. Writeback rd=5, data=0x0000000F in cycle 3.
- SUB x3,x1,x2 (0x402081B3), x1=5, x2=7: alu_sig=1, result 0xFFFFFFFE. SRAI x4,x1,4 (0x4040D213) with x1=0x80000000 gives 0xF8000000.
- Back-pressure: wb_ready low for 5 cycles during WB. wb_valid, rd and data are held constant and instr_ready=0 throughout. Completion occurs on the cycle wb_ready rises.
- Illegal: SLLI with imm[11:5]=0100000 (0x40109093) → illegal pulses one cycle, no wb_valid, instr_ready returns to 1. Opcode 0000011 is rejected the same way.
- rd=x0 (ADDI x0,x0,0, 0x00000013): no wb_valid and instr_ready back at cycle L+2. With L=3, register_1 is held for 3 READ cycles.
- rst asserted in WB with wb_ready=0: next cycle state IDLE, wb_valid=0, all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I/RV64I OP / OP-IMM execute unit:
//   - default datapath and register-select widths
//   - major opcode constants and funct7 patterns
//   - funct3 operation enum and the execute-unit FSM state enum
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT           = 32;
  localparam int REG_SELECT_LEN_DEFAULT = 5;

  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_exec_decode.sv
// -----------------------------------------------------------------------------
// alu_exec_decode
// Purely combinational decoder for OP and OP-IMM instruction words.
// Ports:
//   instruction_i  32-bit instruction word
//   is_imm_o       1 = OP-IMM (second operand from imm_ext_o)
//   is_shift_o     1 = OP-IMM shift (SLLI/SRLI/SRAI)
//   alu_op_o       ALU funct3
//   alu_sig_o      ALU alternate select (SUB / SRA)
//   imm_ext_o      sign-extended imm[11:0], or zero-extended shamt for shifts
//   illegal_o      word is not an encoding this unit executes
// -----------------------------------------------------------------------------
module alu_exec_decode
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instruction_i,
  output logic            is_imm_o,
  output logic            is_shift_o,
  output logic [2:0]      alu_op_o,
  output logic            alu_sig_o,
  output logic [XLEN-1:0] imm_ext_o,
  output logic            illegal_o
);

  // RV64 shifts take a 6-bit shamt, so bit 25 moves from imm[11:5] into shamt.
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam int HI_W    = 12 - SHAMT_W;

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  funct3_e         funct3;
  logic [HI_W-1:0] shift_hi;
  logic            shift_hi_zero;
  logic            shift_hi_alt;
  logic [XLEN-1:0] shamt_ext;
  logic [XLEN-1:0] imm_sext;
  logic            unused_fields;

  assign opcode        = instruction_i[6:0];
  assign funct7        = instruction_i[31:25];
  assign funct3        = funct3_e'(instruction_i[14:12]);
  assign shift_hi      = instruction_i[31:SHAMT_W+20];
  assign shift_hi_zero = (shift_hi == '0);
  assign shift_hi_alt  = (shift_hi == {2'b01, {(HI_W-2){1'b0}}});
  assign shamt_ext     = {{(XLEN-SHAMT_W){1'b0}}, instruction_i[SHAMT_W+19:20]};
  assign imm_sext      = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};

  // Register indices are handled by the top level.
  assign unused_fields = ^{instruction_i[19:15], instruction_i[11:7]};

  always_comb begin
    is_imm_o   = 1'b0;
    is_shift_o = 1'b0;
    alu_op_o   = instruction_i[14:12];
    alu_sig_o  = 1'b0;
    imm_ext_o  = '0;
    illegal_o  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        is_imm_o = 1'b1;
        if (funct3 == F3_SLL) begin
          is_shift_o = 1'b1;
          imm_ext_o  = shamt_ext;
          illegal_o  = !shift_hi_zero;
        end else if (funct3 == F3_SR) begin
          is_shift_o = 1'b1;
          imm_ext_o  = shamt_ext;
          alu_sig_o  = instruction_i[30];
          illegal_o  = !(shift_hi_zero || shift_hi_alt);
        end else begin
          // ADDI etc.: bit 30 is just immediate data, never an ALU modifier.
          imm_ext_o  = imm_sext;
        end
      end
      OPC_OP: begin
        if (funct3 == F3_ADD || funct3 == F3_SR) begin
          alu_sig_o = instruction_i[30];
        end
        if (funct7 == FUNCT7_ALT) begin
          illegal_o = !(funct3 == F3_ADD || funct3 == F3_SR);
        end else if (funct7 != FUNCT7_BASE) begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle execute unit for OP / OP-IMM: accept -> read registers ->
// drive the shared ALU -> write back rd.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid/instr_ready       instruction handshake, instruction sampled on accept
//   instruction                   instruction word
//   register_1/register_2         rs1/rs2 select (READ and EXEC only)
//   register_data_1/_2            register data, valid REG_READ_LATENCY cycles after select
//   alu_a/alu_b/alu_op/alu_sig    ALU operands (EXEC only, 0 elsewhere)
//   alu_out                       combinational ALU result
//   wb_valid/wb_ready             writeback handshake
//   output_register(_data)        rd and result, stable throughout WB
//   illegal                       one-cycle pulse after a rejected word
//   state_o                       current FSM state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid is never withdrawn and its payload never changes until the
// transfer; ready may toggle freely and never depends on the same-cycle valid.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN             = XLEN_DEFAULT,
  parameter int REG_SELECT_LEN   = REG_SELECT_LEN_DEFAULT,
  parameter int REG_READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instruction,
  output logic [REG_SELECT_LEN-1:0] register_1,
  output logic [REG_SELECT_LEN-1:0] register_2,
  input  logic [XLEN-1:0]           register_data_1,
  input  logic [XLEN-1:0]           register_data_2,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [2:0]                alu_op,
  output logic                      alu_sig,
  input  logic [XLEN-1:0]           alu_out,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_SELECT_LEN-1:0] output_register,
  output logic [XLEN-1:0]           output_register_data,
  output logic                      illegal,
  output logic [1:0]                state_o
);

  // READ lasts REG_READ_LATENCY cycles: load latency-1, leave READ at zero.
  localparam logic [1:0] LAT_LOAD = 2'(REG_READ_LATENCY - 1);

  logic            dec_is_imm;
  logic            dec_is_shift;
  logic [2:0]      dec_alu_op;
  logic            dec_alu_sig;
  logic [XLEN-1:0] dec_imm_ext;
  logic            dec_illegal;
  logic            unused_dec;

  state_e          state_q,  state_d;
  logic [1:0]      cnt_q,    cnt_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      rs1_q,    rs1_d;
  logic [4:0]      rs2_q,    rs2_d;
  logic [4:0]      rd_q,     rd_d;
  logic            is_imm_q, is_imm_d;
  logic [2:0]      op_q,     op_d;
  logic            sig_q,    sig_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [XLEN-1:0] result_q, result_d;

  logic accept;
  logic in_exec;
  logic in_wb;
  logic sel_active;

  // Decoding the incoming word (not a latched copy) lets an illegal word be
  // rejected in the accept cycle without ever leaving IDLE.
  alu_exec_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instruction_i (instruction),
    .is_imm_o      (dec_is_imm),
    .is_shift_o    (dec_is_shift),
    .alu_op_o      (dec_alu_op),
    .alu_sig_o     (dec_alu_sig),
    .imm_ext_o     (dec_imm_ext),
    .illegal_o     (dec_illegal)
  );

  // Shift amounts already arrive pre-formatted in imm_ext.
  assign unused_dec = dec_is_shift;

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    is_imm_d  = is_imm_q;
    op_d      = op_q;
    sig_d     = sig_q;
    imm_d     = imm_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            state_d  = ST_READ;
            cnt_d    = LAT_LOAD;
            rs1_d    = instruction[19:15];
            rs2_d    = instruction[24:20];
            rd_d     = instruction[11:7];
            is_imm_d = dec_is_imm;
            op_d     = dec_alu_op;
            sig_d    = dec_alu_sig;
            imm_d    = dec_imm_ext;
          end
        end
      end
      ST_READ: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_EXEC: begin
        result_d = alu_out;
        // Writes to x0 are dropped: no writeback handshake at all.
        state_d  = (rd_q != 5'd0) ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      illegal_q <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      is_imm_q  <= 1'b0;
      op_q      <= 3'd0;
      sig_q     <= 1'b0;
      imm_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      is_imm_q  <= is_imm_d;
      op_q      <= op_d;
      sig_q     <= sig_d;
      imm_q     <= imm_d;
      result_q  <= result_d;
    end
  end

  assign in_exec    = (state_q == ST_EXEC);
  assign in_wb      = (state_q == ST_WB);
  assign sel_active = (state_q == ST_READ) || in_exec;

  assign instr_ready          = (state_q == ST_IDLE);
  assign register_1           = sel_active ? REG_SELECT_LEN'(rs1_q) : '0;
  assign register_2           = sel_active ? REG_SELECT_LEN'(rs2_q) : '0;
  assign alu_a                = in_exec ? register_data_1 : '0;
  assign alu_b                = in_exec ? (is_imm_q ? imm_q : register_data_2) : '0;
  assign alu_op               = in_exec ? op_q : 3'd0;
  assign alu_sig              = in_exec && sig_q;
  assign wb_valid             = in_wb;
  assign output_register      = in_wb ? REG_SELECT_LEN'(rd_q) : '0;
  assign output_register_data = in_wb ? result_q : '0;
  assign illegal              = illegal_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed and random instructions against a behavioural model of OP/OP-IMM
// semantics. The bench also plays the register file (with read latency) and
// the shared ALU that the unit drives.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int L = 3;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [4:0]  register_1;
  logic [4:0]  register_2;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_sig;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  output_register;
  logic [31:0] output_register_data;
  logic        illegal;
  logic [1:0]  state_o;

  int checks;
  int failures;

  logic [31:0] regs [32];
  logic [31:0] pipe1 [L];
  logic [31:0] pipe2 [L];

  alu_exec_unit #(
    .XLEN             (32),
    .REG_SELECT_LEN   (5),
    .REG_READ_LATENCY (L)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instruction          (instruction),
    .register_1           (register_1),
    .register_2           (register_2),
    .register_data_1      (register_data_1),
    .register_data_2      (register_data_2),
    .alu_a                (alu_a),
    .alu_b                (alu_b),
    .alu_op               (alu_op),
    .alu_sig              (alu_sig),
    .alu_out              (alu_out),
    .wb_valid             (wb_valid),
    .wb_ready             (wb_ready),
    .output_register      (output_register),
    .output_register_data (output_register_data),
    .illegal              (illegal),
    .state_o              (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file with L-cycle read latency ----------------
  always @(posedge clk) begin
    pipe1[0] <= regs[register_1];
    pipe2[0] <= regs[register_2];
    for (int i = 1; i < L; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
  end
  assign register_data_1 = pipe1[L-1];
  assign register_data_2 = pipe2[L-1];

  // ---------------- shared ALU ----------------
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      3'd0: alu_out = alu_sig ? (alu_a - alu_b) : (alu_a + alu_b);
      3'd1: alu_out = alu_a << alu_b[4:0];
      3'd2: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'd3: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      3'd4: alu_out = alu_a ^ alu_b;
      3'd5: alu_out = alu_sig ? 32'($signed(alu_a) >>> alu_b[4:0]) : (alu_a >> alu_b[4:0]);
      3'd6: alu_out = alu_a | alu_b;
      3'd7: alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic bit ref_illegal(input logic [31:0] w);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opc = w[6:0];
    f7  = w[31:25];
    f3  = w[14:12];
    if (opc == 7'b0110011)
      return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (opc == 7'b0010011) begin
      if (f3 == 3'd1) return f7 != 7'h00;
      if (f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic ref_exec(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] exp_b, output logic exp_sig,
                          output logic [31:0] exp_res);
    bit          imm;
    logic [2:0]  f3;
    logic [31:0] opnd;
    int          sh;
    imm = (w[6:0] == 7'b0010011);
    f3  = w[14:12];
    if (!imm)                         opnd = b;
    else if (f3 == 3'd1 || f3 == 3'd5) opnd = {27'd0, w[24:20]};
    else                              opnd = {{20{w[31]}}, w[31:20]};
    sh      = int'(opnd[4:0]);
    exp_b   = opnd;
    exp_sig = (f3 == 3'd5 || (!imm && f3 == 3'd0)) ? w[30] : 1'b0;
    case (f3)
      3'd0: exp_res = (!imm && w[30]) ? a - opnd : a + opnd;
      3'd1: exp_res = a << sh;
      3'd2: exp_res = (int'(a) < int'(opnd)) ? 32'd1 : 32'd0;
      3'd3: exp_res = (a < opnd) ? 32'd1 : 32'd0;
      3'd4: exp_res = a ^ opnd;
      3'd5: exp_res = w[30] ? 32'(int'(a) >>> sh) : a >> sh;
      3'd6: exp_res = a | opnd;
      default: exp_res = a & opnd;
    endcase
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_rd"}, 32'(output_register), 32'd0);
    chk({tag, "_data"}, output_register_data, 32'd0);
    chk({tag, "_sel1"}, 32'(register_1), 32'd0);
    chk({tag, "_sel2"}, 32'(register_2), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_sig"}, 32'(alu_sig), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
  endtask

  // ---------------- driver: one instruction, cycle-exact ----------------
  // Called at a negedge with the unit idle. Cycle 0 is the accept cycle.
  task automatic do_instr(input logic [31:0] w, input int hold, input bit rst_in_wb,
                          output logic [31:0] wb_data);
    logic [31:0] a, b, eb, er;
    logic        es;
    bit          bad;
    logic [4:0]  rs1, rs2, rd;
    rs1 = w[19:15];
    rs2 = w[24:20];
    rd  = w[11:7];
    a   = regs[rs1];
    b   = regs[rs2];
    bad = ref_illegal(w);
    ref_exec(w, a, b, eb, es, er);
    wb_data = 32'd0;

    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instruction = w;
    wb_ready    = (hold == 0) && !rst_in_wb;
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = $urandom;

    if (bad) begin
      chk("illegal_pulse", 32'(illegal), 32'd1);
      chk("illegal_ready", 32'(instr_ready), 32'd1);
      chk("illegal_no_wb", 32'(wb_valid), 32'd0);
      chk("illegal_no_sel", 32'(register_1), 32'd0);
      @(negedge clk);
      chk("illegal_clear", 32'(illegal), 32'd0);
      chk("illegal_no_wb2", 32'(wb_valid), 32'd0);
      return;
    end

    for (int c = 1; c <= L + 1; c++) begin
      if (c > 1) @(negedge clk);
      chk("busy_not_ready", 32'(instr_ready), 32'd0);
      chk("no_early_wb", 32'(wb_valid), 32'd0);
      chk("no_illegal", 32'(illegal), 32'd0);
      chk("rs1_sel", 32'(register_1), 32'(rs1));
      chk("rs2_sel", 32'(register_2), 32'(rs2));
      if (c <= L) begin
        chk("alu_a_read", alu_a, 32'd0);
        chk("alu_b_read", alu_b, 32'd0);
      end else begin
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, eb);
        chk("alu_op", 32'(alu_op), 32'(w[14:12]));
        chk("alu_sig", 32'(alu_sig), 32'(es));
      end
    end

    @(negedge clk);  // cycle L+2
    chk("sel1_after_exec", 32'(register_1), 32'd0);
    chk("alu_a_after_exec", alu_a, 32'd0);
    if (rd == 5'd0) begin
      chk("x0_ready", 32'(instr_ready), 32'd1);
      chk("x0_no_wb", 32'(wb_valid), 32'd0);
      return;
    end
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_rd", 32'(output_register), 32'(rd));
    chk("wb_data", output_register_data, er);
    chk("wb_not_ready", 32'(instr_ready), 32'd0);
    wb_data = output_register_data;

    if (rst_in_wb) begin
      rst      = 1'b1;
      wb_ready = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_wb");
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("post_rst");
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
      return;
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(wb_valid), 32'd1);
      chk("hold_rd", 32'(output_register), 32'(rd));
      chk("hold_data", output_register_data, er);
      chk("hold_not_ready", 32'(instr_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("wb_done", 32'(wb_valid), 32'd0);
    chk("back_ready", 32'(instr_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  logic [31:0] rw;
  logic [11:0] rimm;
  logic [6:0]  rf7;
  logic [2:0]  rf3;
  logic [4:0]  rrd, rrs1, rrs2;
  int          kind;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    wb_ready    = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk_all_zero("reset");

    // ADDI x5,x1,-1
    regs[1] = 32'h0000_0010;
    do_instr(32'hFFF08293, 0, 1'b0, d);
    chk("addi_result", d, 32'h0000_000F);

    // SUB x3,x1,x2
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    do_instr(32'h402081B3, 0, 1'b0, d);
    chk("sub_result", d, 32'hFFFF_FFFE);

    // SRAI x4,x1,4
    regs[1] = 32'h8000_0000;
    do_instr(32'h4040D213, 0, 1'b0, d);
    chk("srai_result", d, 32'hF800_0000);

    // ADD x6,x1,x2 with 5 cycles of back-pressure
    regs[1] = 32'h1234_5678;
    regs[2] = 32'h0101_0101;
    do_instr(32'h00208333, 5, 1'b0, d);
    chk("bp_result", d, 32'h1335_5779);

    // illegal: SLLI with imm[11:5]=0100000, a load opcode, OP alt with SLL
    do_instr(32'h40109093, 0, 1'b0, d);
    do_instr(32'h00012083, 0, 1'b0, d);
    do_instr(32'h40209133, 0, 1'b0, d);

    // ADDI x0,x0,0: no writeback, ready again at L+2
    do_instr(32'h00000013, 0, 1'b0, d);

    // reset in WB with writeback pending
    do_instr(32'h00208333, 0, 1'b1, d);

    // random mix
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rf3  = 3'($urandom_range(0, 7));
      rrd  = 5'($urandom_range(1, 31));
      rrs1 = 5'($urandom_range(0, 31));
      rrs2 = 5'($urandom_range(0, 31));
      rimm = 12'($urandom);
      if (kind <= 3) begin
        rf7 = ((rf3 == 3'd0 || rf3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        rw  = {rf7, rrs2, rrs1, rf3, rrd, 7'b0110011};
      end else if (kind <= 6) begin
        if (rf3 == 3'd1) rimm = {7'h00, rimm[4:0]};
        if (rf3 == 3'd5) rimm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rimm[4:0]};
        rw = {rimm, rrs1, rf3, rrd, 7'b0010011};
      end else if (kind == 7) begin
        rw = {rimm, rrs1, 3'd0, 5'd0, 7'b0010011};
      end else if (kind == 8) begin
        rw = $urandom;
      end else begin
        rf7 = 7'($urandom);
        rw  = {rf7, rimm[4:0], rrs1, ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5, rrd, 7'b0010011};
      end
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
      do_instr(rw, $urandom_range(0, 2), 1'b0, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
